pattern_timer_ctrl: RTL and testbench
=====================================

# pattern_timer_ctrl

Controller that sequences a 4-cycle shift-enable datapath: it watches a serial input for a start pattern, asserts `shift_ena` for exactly `DELAY_W` cycles to load a delay value, then times `(delay+1)*UNIT_CYCLES` cycles. When the count expires it raises `done` and waits for an acknowledge. It sits above the shift-register/enable block as its sequencer and owns the only `shift_ena` driver in the subsystem.

## Interface
- `PATTERN_W`, 4, length of start pattern in bits
- `PATTERN`, 4'b1101, start pattern; first-received bit is the MSB
- `DELAY_W`, 4, delay field width = number of shift cycles
- `UNIT_CYCLES`, 1000, clock cycles per delay unit (>=1)
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  synchronous active-low reset
- `data`  in  1  serial input, sampled every rising edge
- `ack`  in  1  acknowledge of `done`
- `shift_ena`  out  1  high while delay bits are shifted in
- `counting`  out  1  high during timed interval
- `done`  out  1  high from timer expiry until `ack` is sampled
- `count`  out  DELAY_W  remaining delay units during COUNT, else 0

## Operation
- States: SEARCH, SHIFT, COUNT, DONE. All outputs are registered or decoded from state; no combinational path from inputs to outputs.
- SEARCH: shift `data` into a PATTERN_W-bit history. When history (including the bit sampled this edge) equals `PATTERN`, go to SHIFT. Overlapping prefixes count (1,1,1,0,1 detects).
- SHIFT: `shift_ena`=1. At each of DELAY_W edges, shift `data` into the delay register MSB first. After the DELAY_W-th bit, load the unit counter with UNIT_CYCLES-1 and go to COUNT.
- COUNT: `counting`=1, `count`=delay register. The unit counter decrements each cycle. At 0 with delay≠0, decrement delay and reload the counter. At 0 with delay=0, go to DONE.
- DONE: `done`=1. Go to SEARCH on the edge where `ack`=1, and clear the pattern history so no bits sampled before re-entry contribute.
- `ack` is ignored outside DONE. `data` is ignored in COUNT and DONE.
- Delay counter width is DELAY_W and never wraps, because it reaches 0 only at the terminal step. Unit counter width is clog2(UNIT_CYCLES) (min 1).

## Timing
- Reset (`resetn`=0 at an edge): state SEARCH, history 0, delay 0, unit counter 0. `shift_ena`=0, `counting`=0, `done`=0, `count`=0 from the next cycle.
- Reset has priority over every state, including mid-SHIFT and mid-COUNT. It aborts immediately with no `done` pulse.
- Pattern completes at edge E. `shift_ena` is high in the DELAY_W cycles after E, and the delay bits are sampled at edges E+1..E+DELAY_W.
- `counting` is high for exactly (delay+1)*UNIT_CYCLES cycles, starting the cycle after edge E+DELAY_W.
- `count` shows delay for the first UNIT_CYCLES counting cycles, then delay-1, and so on, with 0 in the last UNIT_CYCLES cycles.
- `done` rises the cycle after the last counting cycle. If `ack` is already high then, `done` lasts exactly 1 cycle.
- After the `ack` edge, SEARCH accepts a new pattern. The earliest re-detection is PATTERN_W edges later.
- Delay=0 gives UNIT_CYCLES counting cycles. Delay=2^DELAY_W-1 gives 2^DELAY_W*UNIT_CYCLES cycles.

## Test plan
All scenarios use UNIT_CYCLES=4.
- Reset: hold `resetn`=0 for 2 cycles with `data` toggling -> all outputs 0, no `shift_ena`.
- Nominal: `data` 1,1,0,1 then 0,0,1,0 (delay 2) -> `shift_ena` high 4 cycles, `counting` high 12 cycles with `count` 2,2,2,2,1,1,1,1,0,0,0,0, then `done`=1. `ack`=1 three cycles later -> `done` drops, state SEARCH.
- Overlap/near-miss: stream 1,1,1,0,1 -> detect on 5th bit. Stream 1,1,0,0,1,1,0,1 -> detect only on 8th bit.
- Extremes: delay 0 -> 4 counting cycles, `count`=0. Delay 15 -> 64 counting cycles, `count` starting at 15.
- Ack/data ignore: `ack`=1 held during SHIFT/COUNT -> no effect, `done` still asserts and drops 1 cycle later. Pattern bits fed during COUNT -> no new SHIFT.
- Reset mid-operation: deassert `resetn` mid-SHIFT and again mid-COUNT -> outputs 0 next cycle. A fresh 1101 afterward restarts correctly.

Source files
------------

// File: rtl/pattern_timer_ctrl_if.sv
// Handshake bundle between the pattern/timer sequencer and its environment.
// The slave side is the sequencer: it samples data/ack and drives the status.
interface pattern_timer_ctrl_if #(
  parameter int DELAY_W = 4
);
  logic               data;
  logic               ack;
  logic               shift_ena;
  logic               counting;
  logic               done;
  logic [DELAY_W-1:0] count;

  modport master (
    output data,
    output ack,
    input  shift_ena,
    input  counting,
    input  done,
    input  count
  );

  modport slave (
    input  data,
    input  ack,
    output shift_ena,
    output counting,
    output done,
    output count
  );
endinterface

// File: rtl/pattern_timer_ctrl.sv
// Sequencer: finds a serial start pattern, shifts in a DELAY_W-bit delay,
// times (delay+1)*UNIT_CYCLES cycles, then holds done until acknowledged.
// All status outputs are registered from the next-state values, so there is
// no combinational path from data/ack to any output.
module pattern_timer_ctrl #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] PATTERN     = 4'b1101,
  parameter int                   DELAY_W     = 4,
  parameter int                   UNIT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                resetn,
  pattern_timer_ctrl_if.slave bus
);

  localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int BIT_W  = $clog2(DELAY_W + 1);
  localparam logic [UNIT_W-1:0] UNIT_LOAD = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DELAY_W - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic [UNIT_W-1:0]    unit_q, unit_d;
  logic [BIT_W-1:0]     bits_q, bits_d;
  logic                 shift_ena_q, counting_q, done_q;
  logic [DELAY_W-1:0]   count_q;
  logic [PATTERN_W:0]   hist_shift_s;
  logic [DELAY_W:0]     delay_shift_s;

  // Next-state logic: pattern search, delay shift-in, unit/delay countdown, ack wait.
  always_comb begin
    state_d       = state_q;
    hist_d        = hist_q;
    delay_d       = delay_q;
    unit_d        = unit_q;
    bits_d        = bits_q;
    hist_shift_s  = {hist_q, bus.data};
    delay_shift_s = {delay_q, bus.data};
    case (state_q)
      ST_SEARCH: begin
        // The bit sampled on this edge takes part in the comparison.
        hist_d = hist_shift_s[PATTERN_W-1:0];
        if (hist_d == PATTERN) begin
          state_d = ST_SHIFT;
          bits_d  = BIT_W'(0);
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_SHIFT: begin
        delay_d = delay_shift_s[DELAY_W-1:0];
        bits_d  = bits_q + BIT_W'(1);
        if (bits_q == BIT_LAST) begin
          state_d = ST_COUNT;
          unit_d  = UNIT_LOAD;
          bits_d  = BIT_W'(0);
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COUNT: begin
        if (unit_q == UNIT_W'(0)) begin
          // Delay only reaches zero on the terminal unit, so it never wraps.
          if (delay_q == DELAY_W'(0)) begin
            state_d = ST_DONE;
          end else begin
            delay_d = delay_q - DELAY_W'(1);
            unit_d  = UNIT_LOAD;
          end
        end else begin
          unit_d = unit_q - UNIT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.ack) begin
          // Forget stale bits so re-detection needs a full fresh pattern.
          state_d = ST_SEARCH;
          hist_d  = PATTERN_W'(0);
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        hist_d  = PATTERN_W'(0);
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset; outputs
  // are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_SEARCH;
      hist_q      <= PATTERN_W'(0);
      delay_q     <= DELAY_W'(0);
      unit_q      <= UNIT_W'(0);
      bits_q      <= BIT_W'(0);
      shift_ena_q <= 1'b0;
      counting_q  <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= DELAY_W'(0);
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      delay_q     <= delay_d;
      unit_q      <= unit_d;
      bits_q      <= bits_d;
      shift_ena_q <= (state_d == ST_SHIFT);
      counting_q  <= (state_d == ST_COUNT);
      done_q      <= (state_d == ST_DONE);
      count_q     <= (state_d == ST_COUNT) ? delay_d : DELAY_W'(0);
    end
  end

  assign bus.shift_ena = shift_ena_q;
  assign bus.counting  = counting_q;
  assign bus.done      = done_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_pattern_timer_ctrl.sv
// Self-checking bench for pattern_timer_ctrl with UNIT_CYCLES=4: a vector
// table for the nominal flow, directed corner sequences, and a random run,
// all compared against a cycle-level behavioural model.
module tb_pattern_timer_ctrl;

  localparam int PW = 4;
  localparam int DW = 4;
  localparam int UC = 4;
  localparam int PAT = 13;  // 4'b1101

  localparam int M_SEARCH = 0;
  localparam int M_SHIFT  = 1;
  localparam int M_COUNT  = 2;
  localparam int M_DONE   = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pattern_timer_ctrl_if #(.DELAY_W(DW)) bus ();

  pattern_timer_ctrl #(
    .PATTERN_W  (PW),
    .PATTERN    (4'b1101),
    .DELAY_W    (DW),
    .UNIT_CYCLES(UC)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode plus remaining-cycle count for the timed window.
  int m_mode = M_SEARCH;
  int m_hist = 0;
  int m_nbits = 0;
  int m_dval = 0;
  int m_rem = 0;

  // Tallies of observed status over a run.
  int t_counting = 0;
  int t_done = 0;
  int t_first = -1;

  typedef struct {
    bit r; bit d; bit a;
    bit sh; bit cn; bit dn; int cnt;
  } vec_t;
  vec_t vecs[26];

  function automatic void model_step(bit r, bit d, bit a);
    if (!r) begin
      m_mode = M_SEARCH; m_hist = 0; m_nbits = 0; m_dval = 0; m_rem = 0;
    end else begin
      case (m_mode)
        M_SEARCH: begin
          m_hist = ((m_hist << 1) | int'(d)) & ((1 << PW) - 1);
          if (m_hist == PAT) begin
            m_mode = M_SHIFT; m_nbits = 0; m_dval = 0;
          end
        end
        M_SHIFT: begin
          m_dval = m_dval * 2 + int'(d);
          m_nbits++;
          if (m_nbits == DW) begin
            m_mode = M_COUNT; m_rem = (m_dval + 1) * UC;
          end
        end
        M_COUNT: begin
          m_rem--;
          if (m_rem == 0) m_mode = M_DONE;
        end
        default: begin
          if (a) begin
            m_mode = M_SEARCH; m_hist = 0;
          end
        end
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare on the falling edge.
  task automatic cycle(input bit r, input bit d, input bit a);
    resetn   = r;
    bus.data = d;
    bus.ack  = a;
    @(posedge clk);
    model_step(r, d, a);
    @(negedge clk);
    chk("shift_ena", 32'(bus.shift_ena), 32'(m_mode == M_SHIFT));
    chk("counting",  32'(bus.counting),  32'(m_mode == M_COUNT));
    chk("done",      32'(bus.done),      32'(m_mode == M_DONE));
    chk("count",     32'(bus.count),     (m_mode == M_COUNT) ? 32'((m_rem - 1) / UC) : 32'd0);
    if (bus.counting === 1'b1) begin
      if (t_counting == 0) t_first = int'(bus.count);
      t_counting++;
    end
    if (bus.done === 1'b1) t_done++;
  endtask

  task automatic send_nibble(input logic [3:0] v, input bit a);
    for (int i = 3; i >= 0; i--) cycle(1'b1, v[i], a);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (m_mode == M_SEARCH) break;
      cycle(1'b1, 1'($urandom_range(1, 0)), 1'b1);
    end
    chk("idle_timeout", 32'(m_mode), 32'(M_SEARCH));
  endtask

  // Pattern, delay, then run to completion with ack held high throughout.
  task automatic run_delay(input logic [3:0] dly);
    send_nibble(4'b1101, 1'b1);
    chk("detect", 32'(bus.shift_ena), 32'd1);
    t_counting = 0; t_done = 0; t_first = -1;
    send_nibble(dly, 1'b1);
    wait_idle();
    chk("count_cycles", 32'(t_counting), 32'((int'(dly) + 1) * UC));
    chk("first_count",  32'(t_first),    32'(dly));
    chk("done_cycles",  32'(t_done),     32'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_shift"}, 32'(bus.shift_ena), 32'd0);
    chk({tag, "_cnt"},   32'(bus.counting),  32'd0);
    chk({tag, "_done"},  32'(bus.done),      32'd0);
    chk({tag, "_count"}, 32'(bus.count),     32'd0);
  endtask

  initial begin
    logic [7:0] near_miss;
    logic [4:0] overlap;
    bus.data = 1'b0;
    bus.ack  = 1'b0;
    @(negedge clk);

    // Reset with toggling data, pattern 1101, delay 0010, ack three cycles after done.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[24] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    for (int i = 0; i < 26; i++) begin
      cycle(vecs[i].r, vecs[i].d, vecs[i].a);
      chk($sformatf("vec%0d_shift", i), 32'(bus.shift_ena), 32'(vecs[i].sh));
      chk($sformatf("vec%0d_cnt", i),   32'(bus.counting),  32'(vecs[i].cn));
      chk($sformatf("vec%0d_done", i),  32'(bus.done),      32'(vecs[i].dn));
      chk($sformatf("vec%0d_count", i), 32'(bus.count),     32'(vecs[i].cnt));
    end

    // Overlapping prefix: 1,1,1,0,1 detects on the fifth bit only.
    cycle(1'b0, 1'b0, 1'b0);
    overlap = 5'b11101;
    for (int i = 4; i >= 0; i--) begin
      cycle(1'b1, overlap[i], 1'b0);
      chk($sformatf("overlap_bit%0d", 4 - i), 32'(bus.shift_ena), 32'(i == 0));
    end
    send_nibble(4'b0000, 1'b0);
    wait_idle();

    // Near miss: 1,1,0,0,1,1,0,1 detects on the eighth bit only.
    near_miss = 8'b11001101;
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, near_miss[i], 1'b0);
      chk($sformatf("nearmiss_bit%0d", 7 - i), 32'(bus.shift_ena), 32'(i == 0));
    end
    send_nibble(4'b0000, 1'b0);
    wait_idle();

    // Extremes and ack held high through SHIFT/COUNT.
    run_delay(4'd0);
    run_delay(4'd15);
    run_delay(4'd2);

    // Pattern bits during COUNT must not restart the shift phase.
    send_nibble(4'b1101, 1'b0);
    t_counting = 0; t_done = 0; t_first = -1;
    send_nibble(4'b0011, 1'b0);
    send_nibble(4'b1101, 1'b0);
    chk("count_ignore_shift", 32'(bus.shift_ena), 32'd0);
    chk("count_ignore_cnt",   32'(bus.counting),  32'd1);
    wait_idle();
    chk("count_ignore_total", 32'(t_counting), 32'(4 * UC));

    // Reset mid-SHIFT, then a clean restart.
    send_nibble(4'b1101, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk_zero("rst_shift");
    run_delay(4'd1);

    // Reset mid-COUNT, then a clean restart.
    send_nibble(4'b1101, 1'b0);
    send_nibble(4'b0010, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk_zero("rst_count");
    run_delay(4'd3);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(99, 0) != 0),
            1'($urandom_range(1, 0)),
            1'($urandom_range(3, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
